// File: rtl/div_sequencer.sv
// Operand-issue and result-buffering stage in front of a multi-cycle
// fixed-point divider. Holds one division in flight, resolves divide-by-zero
// locally with a saturated quotient, aborts a hung divider after TIMEOUT
// cycles and returns tagged results through a 2-entry output FIFO.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid must not depend on ready, and payload is only meaningful
// while valid is high.
module div_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  div_start,
  output logic                  div_rst,
  output logic [DATA_WIDTH-1:0] div_a,
  output logic [DATA_WIDTH-1:0] div_b,
  input  logic                  div_done,
  input  logic [DATA_WIDTH-1:0] div_quot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [1:0]            out_flags,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Counter is wide enough to hold TIMEOUT itself, so it never wraps
  // before the abort compare fires.
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                  state;
  state_t                  next_state;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [CW-1:0]           wait_count;
  logic                    abort_q;

  logic                    accept;
  logic                    pop;
  logic                    push;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   push_q;
  logic [TAG_WIDTH-1:0]    push_tag;
  logic [1:0]              push_flags;

  logic [DATA_WIDTH-1:0]   fifo_q     [2];
  logic [TAG_WIDTH-1:0]    fifo_tag   [2];
  logic [1:0]              fifo_flags [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              fifo_count;

  assign in_ready  = (state == IDLE) && (fifo_count < 2'd2) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;

  assign div_start = (state == ISSUE);
  assign div_rst   = rst || abort_q;
  assign div_a     = a_q;
  assign div_b     = b_q;

  assign out_q     = fifo_q[rd_ptr];
  assign out_tag   = fifo_tag[rd_ptr];
  assign out_flags = fifo_flags[rd_ptr];
  assign fsm_state = state;

  // Next-state and FIFO write selection; zero divisors bypass the divider.
  always_comb begin
    next_state  = state;
    push        = 1'b0;
    push_q      = '0;
    push_tag    = tag_q;
    push_flags  = 2'b00;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_b == '0) begin
            push       = 1'b1;
            push_q     = in_a[DATA_WIDTH-1] ? SAT_NEG : SAT_POS;
            push_tag   = in_tag;
            push_flags = 2'b01;
          end else begin
            next_state = ISSUE;
          end
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        // A result arriving on the abort edge still counts as a result.
        if (div_done) begin
          push       = 1'b1;
          push_q     = div_quot;
          next_state = IDLE;
        end else if (wait_count == LAST) begin
          push        = 1'b1;
          push_flags  = 2'b10;
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operand registers hold the divider inputs steady for the whole operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b;
      tag_q <= in_tag;
    end
  end

  // Cycles spent in WAIT; cleared while the start pulse is out.
  always_ff @(posedge clk) begin
    if (rst)                 wait_count <= '0;
    else if (state == ISSUE) wait_count <= '0;
    else if (state == WAIT)  wait_count <= wait_count + 1'b1;
  end

  // One-cycle divider reset following an abort.
  always_ff @(posedge clk) begin
    if (rst) abort_q <= 1'b0;
    else     abort_q <= timeout_hit;
  end

  // 2-entry circular result FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i]     <= '0;
        fifo_tag[i]   <= '0;
        fifo_flags[i] <= '0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr]     <= push_q;
        fifo_tag[wr_ptr]   <= push_tag;
        fifo_flags[wr_ptr] <= push_flags;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: Q8.8 divider stub with programmable latency,
// result scoreboard with an expected queue, directed scenarios.
module tb_div_sequencer;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int TO = 64;
  localparam int EW = DW + TW + 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          div_start;
  logic          div_rst;
  logic [DW-1:0] div_a;
  logic [DW-1:0] div_b;
  logic          div_done = 1'b0;
  logic [DW-1:0] div_quot = 16'hBEEF;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_q;
  logic [TW-1:0] out_tag;
  logic [1:0]    out_flags;
  logic [1:0]    fsm_state;

  div_sequencer #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_start(div_start), .div_rst(div_rst),
    .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_quot(div_quot),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_tag(out_tag), .out_flags(out_flags),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and helpers ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Q8.8 signed division, truncating toward zero.
  function automatic logic [DW-1:0] q88(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint x;
    longint y;
    longint r;
    x = $signed(a);
    y = $signed(b);
    r = (x * 256) / y;
    return r[DW-1:0];
  endfunction

  // ---------------- divider stub ----------------
  // div_lat = cycles from start to done; 0 means the divider never answers.
  int div_lat = 34;
  int rem = 0;
  bit busy = 1'b0;
  logic [DW-1:0] mq = '0;

  always @(negedge clk) begin
    div_done = 1'b0;
    div_quot = 16'hBEEF;
    if (busy) begin
      rem--;
      if (rem == 0) begin
        div_done = 1'b1;
        div_quot = mq;
        busy = 1'b0;
      end
    end else if (div_start && div_lat != 0) begin
      busy = 1'b1;
      rem  = div_lat;
      mq   = q88(div_a, div_b);
    end
  end

  // Expected result for a request, from the rules of the stage.
  function automatic logic [EW-1:0] expected(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [TW-1:0] t);
    if (b == '0)
      return {(a[DW-1] ? 16'h8000 : 16'h7FFF), t, 2'b01};
    else if (div_lat == 0 || div_lat > TO)
      return {16'h0000, t, 2'b10};
    else
      return {q88(a, b), t, 2'b00};
  endfunction

  // ---------------- pulse monitors ----------------
  int start_cnt = 0;
  int rstp_cnt  = 0;
  int rstp_cyc  = -1;
  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (div_rst && !rst) begin
      rstp_cnt++;
      rstp_cyc = cyc;
    end
  end

  // ---------------- scoreboard compare ----------------
  bit have_prev = 1'b0;
  logic [EW-1:0] prev_head = '0;
  initial begin
    logic [EW-1:0] head;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      head = {out_q, out_tag, out_flags};
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_head", 64'(head), 64'(prev_head));
        end
        have_prev = out_valid && !out_ready;
        prev_head = head;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(head), 64'h3FFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'(head), 64'(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
    int n;
    n = 0;
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_bound", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(expected(a, b, t));
      @(negedge clk);
      in_valid = 1'b0;
      acc_cyc = cyc;
    end
  endtask

  // Latency counted so that a result visible right after the accept edge is 1.
  task automatic wait_valid(output int lat, output int seen);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_bound", 64'd0, 64'd1);
    lat  = cyc - acc_cyc + 1;
    seen = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int seen;
    int s0;
    int r0;
    int v;

    idle(2);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_div_rst", 64'(div_rst), 64'd1);
    idle(1);
    rst = 1'b0;
    idle(1);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_div_rst", 64'(div_rst), 64'd0);
    chk("post_rst_outs", 64'({out_valid, out_q, out_tag, out_flags, div_start}), 64'd0);
    chk("post_rst_ops", 64'({div_a, div_b}), 64'd0);
    chk("post_rst_state", 64'(fsm_state), 64'(ST_IDLE));

    // Nonzero divide, latency 34: 3.0 / 2.0 = 1.5
    div_lat = 34;
    s0 = start_cnt;
    send(16'h0300, 16'h0200, 4'd3);
    chk("issue_start", 64'(div_start), 64'd1);
    chk("issue_in_ready", 64'(in_ready), 64'd0);
    wait_valid(lat, seen);
    chk("lat_34", 64'(lat), 64'd36);
    chk("head_1p5", 64'({out_q, out_tag, out_flags}), 64'({16'h0180, 4'd3, 2'b00}));
    chk("ready_after_push", 64'(in_ready), 64'd1);
    chk("start_pulses", 64'(start_cnt - s0), 64'd1);
    idle(2);

    // Minimum latency: 1.0 / 0.25 = 4.0
    div_lat = 1;
    send(16'h0100, 16'h0040, 4'd4);
    wait_valid(lat, seen);
    chk("lat_min", 64'(lat), 64'd3);
    chk("head_4p0", 64'({out_q, out_tag, out_flags}), 64'({16'h0400, 4'd4, 2'b00}));
    idle(2);

    // Divide by zero, negative and positive dividend
    s0 = start_cnt;
    send(16'hFD00, 16'h0000, 4'd5);
    wait_valid(lat, seen);
    chk("lat_zero", 64'(lat), 64'd1);
    chk("head_zero_neg", 64'({out_q, out_tag, out_flags}), 64'({16'h8000, 4'd5, 2'b01}));
    idle(2);
    send(16'h0100, 16'h0000, 4'd6);
    wait_valid(lat, seen);
    chk("head_zero_pos", 64'({out_q, out_tag, out_flags}), 64'({16'h7FFF, 4'd6, 2'b01}));
    chk("zero_no_start", 64'(start_cnt - s0), 64'd0);
    idle(2);

    // Back-pressure: two zero-divisor results fill the FIFO, third waits
    out_ready = 1'b0;
    send(16'h0200, 16'h0000, 4'd7);
    send(16'h8000, 16'h0000, 4'd8);
    in_a = 16'h0000; in_b = 16'h0000; in_tag = 4'd9; in_valid = 1'b1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    idle(3);
    chk("full_in_ready_held", 64'(in_ready), 64'd0);
    chk("full_head_tag", 64'({out_valid, out_tag}), 64'({1'b1, 4'd7}));
    out_ready = 1'b1;
    send(16'h0000, 16'h0000, 4'd9);
    idle(4);
    chk("drained_fifo", 64'(out_valid), 64'd0);

    // Timeout: divider never answers
    div_lat = 0;
    r0 = rstp_cnt;
    send(16'h0100, 16'h0100, 4'd10);
    wait_valid(lat, seen);
    chk("lat_timeout", 64'(lat), 64'(TO + 2));
    chk("head_timeout", 64'({out_q, out_tag, out_flags}), 64'({16'h0000, 4'd10, 2'b10}));
    chk("timeout_state", 64'(fsm_state), 64'(ST_IDLE));
    idle(1);
    chk("timeout_rst_pulses", 64'(rstp_cnt - r0), 64'd1);
    chk("timeout_rst_cycle", 64'(rstp_cyc), 64'(seen));
    idle(1);

    // Normal issue after an abort: 4.0 / 2.0 = 2.0
    div_lat = 34;
    s0 = start_cnt;
    send(16'h0400, 16'h0200, 4'd11);
    wait_valid(lat, seen);
    chk("lat_after_abort", 64'(lat), 64'd36);
    chk("start_after_abort", 64'(start_cnt - s0), 64'd1);
    idle(3);

    // Reset in the 10th WAIT cycle with one result held in the FIFO
    out_ready = 1'b0;
    send(16'h0100, 16'h0000, 4'd12);
    div_lat = 20;
    send(16'h0100, 16'h0100, 4'd13);
    idle(10);
    chk("pre_rst_state", 64'(fsm_state), 64'(ST_WAIT));
    rst = 1'b1;
    idle(1);
    chk("mid_rst_div_rst", 64'(div_rst), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_state", 64'(fsm_state), 64'(ST_IDLE));
    out_ready = 1'b1;
    v = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) v++;
    end
    chk("late_done_ignored", 64'(v), 64'd0);

    // div_done on the same edge as the timeout: 6.0 / 3.0 = 2.0
    div_lat = TO;
    r0 = rstp_cnt;
    send(16'h0600, 16'h0300, 4'd14);
    wait_valid(lat, seen);
    chk("lat_tie", 64'(lat), 64'(TO + 2));
    chk("head_tie", 64'({out_q, out_tag, out_flags}), 64'({16'h0200, 4'd14, 2'b00}));
    idle(2);
    chk("tie_no_div_rst", 64'(rstp_cnt - r0), 64'd0);

    idle(4);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
